hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 148 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage register-hazard tracker for a 5-stage MIPS pipeline.
// Keeps a remaining-latency counter for every GPR (1..31) plus HI (32) and LO (33).
// From these counters it reports whether decode must stall and how many cycles the stall lasts.
// A one-deep record of the last issue lets a branch squash undo that issue's writes.
module hazard_scoreboard #(
  parameter int LAT_W   = 3,
  parameter bit HILO_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_we,
  input  logic [4:0]       issue_dst,
  input  logic             issue_hi,
  input  logic             issue_lo,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic [4:0]       src1,
  input  logic             src1_used,
  input  logic [4:0]       src2,
  input  logic             src2_used,
  input  logic             src_hi,
  input  logic             src_lo,
  input  logic             flush,
  output logic             hazard,
  output logic [LAT_W-1:0] hazard_amt,
  output logic [33:0]      pending,
  output logic             idle
);

  localparam int NUM_ENT = 34;
  localparam int NUM_GPR = 32;
  localparam int HI_IDX  = 32;
  localparam int LO_IDX  = 33;

  typedef logic [LAT_W-1:0] cnt_t;

  // One cycle of elapsed time, never going below zero.
  function automatic cnt_t dec_sat(input cnt_t v);
    return (v != '0) ? v - cnt_t'(1) : '0;
  endfunction

  // Two cycles of elapsed time, never going below zero.
  function automatic cnt_t sub2_sat(input cnt_t v);
    return (v > cnt_t'(1)) ? v - cnt_t'(2) : '0;
  endfunction

  function automatic cnt_t max_cnt(input cnt_t a, input cnt_t b);
    return (a > b) ? a : b;
  endfunction

  // Architectural state: per-entry remaining latency.
  cnt_t cnt_q [NUM_ENT];
  cnt_t cnt_d [NUM_ENT];

  // Record of the previous cycle's issue, used to undo it on a squash.
  logic               rec_valid_q, rec_valid_d;
  logic [NUM_ENT-1:0] rec_mask_q,  rec_mask_d;
  cnt_t               rec_old_q [NUM_ENT];
  cnt_t               rec_old_d [NUM_ENT];

  logic               idle_q, idle_d;

  logic [NUM_ENT-1:0] wr_mask;
  logic [NUM_ENT-1:0] pending_d;
  cnt_t               query_amt;

  // Entries the current issue would write; GPR 0 and zero latency never load.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no path can leave it holding its old value (a latch).
    wr_mask = '0;
    if (issue_valid && !flush && issue_lat != '0) begin
      for (int i = 1; i < NUM_GPR; i++) begin
        if (issue_we && issue_dst == 5'(i)) wr_mask[i] = 1'b1;
      end
      if (HILO_EN) begin
        wr_mask[HI_IDX] = issue_hi;
        wr_mask[LO_IDX] = issue_lo;
      end
    end
  end

  // Counter next state: a squash restores, otherwise a load wins, otherwise decrement.
  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) begin
      cnt_d[i] = dec_sat(cnt_q[i]);
      if (flush) begin
        if (rec_valid_q && rec_mask_q[i]) cnt_d[i] = sub2_sat(rec_old_q[i]);
      end else if (wr_mask[i]) begin
        cnt_d[i] = issue_lat;
      end
      if (!HILO_EN && i >= HI_IDX) cnt_d[i] = '0;
    end
  end

  // Issue record next state: remembers the pre-issue counters of a surviving issue.
  always_comb begin
    rec_valid_d = issue_valid && !flush;
    rec_mask_d  = wr_mask;
    for (int i = 0; i < NUM_ENT; i++) rec_old_d[i] = cnt_q[i];
  end

  // Idle looks ahead at the next-state counters, so it is correct in the cycle after each edge.
  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) pending_d[i] = (cnt_d[i] != '0);
    idle_d = ~|pending_d;
  end

  // Hazard query over the relevant sources, taken from current state only.
  always_comb begin
    query_amt = '0;
    if (src1_used && src1 != 5'd0) query_amt = max_cnt(query_amt, cnt_q[src1]);
    if (src2_used && src2 != 5'd0) query_amt = max_cnt(query_amt, cnt_q[src2]);
    if (HILO_EN && src_hi)         query_amt = max_cnt(query_amt, cnt_q[HI_IDX]);
    if (HILO_EN && src_lo)         query_amt = max_cnt(query_amt, cnt_q[LO_IDX]);
  end

  // Per-entry busy flags straight from the counters.
  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) pending[i] = (cnt_q[i] != '0);
  end

  assign hazard     = (query_amt != '0);
  assign hazard_amt = query_amt;
  assign idle       = idle_q;

  // Counters, record control and idle; reset discards all tracked writes.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples the pre-edge values; a blocking = here would create order-dependent logic.
    if (rst) begin
      for (int i = 0; i < NUM_ENT; i++) cnt_q[i] <= '0;
      rec_valid_q <= 1'b0;
      rec_mask_q  <= '0;
      idle_q      <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_ENT; i++) cnt_q[i] <= cnt_d[i];
      rec_valid_q <= rec_valid_d;
      rec_mask_q  <= rec_mask_d;
      idle_q      <= idle_d;
    end
  end

  // Saved pre-issue values.
  always_ff @(posedge clk) begin
    // NOTE: this array is deliberately not reset; it is only read under rec_valid_q, which reset clears.
    for (int i = 0; i < NUM_ENT; i++) rec_old_q[i] <= rec_old_d[i];
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios with literal expectations, then randomized
// traffic checked against a deadline-based model.
// The model stores, for each entry, the absolute cycle at which its result becomes readable.
module tb_hazard_scoreboard;

  localparam int LAT_W = 3;
  localparam int N     = 34;

  logic             clk;
  logic             rst;
  logic             issue_valid, issue_we, issue_hi, issue_lo;
  logic [4:0]       issue_dst;
  logic [LAT_W-1:0] issue_lat;
  logic [4:0]       src1, src2;
  logic             src1_used, src2_used, src_hi, src_lo;
  logic             flush;
  logic             hazard;
  logic [LAT_W-1:0] hazard_amt;
  logic [33:0]      pending;
  logic             idle;

  int n_checks = 0;
  int n_errors = 0;

  hazard_scoreboard #(.LAT_W(LAT_W), .HILO_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_dst(issue_dst),
    .issue_hi(issue_hi), .issue_lo(issue_lo), .issue_lat(issue_lat),
    .src1(src1), .src1_used(src1_used), .src2(src2), .src2_used(src2_used),
    .src_hi(src_hi), .src_lo(src_lo), .flush(flush),
    .hazard(hazard), .hazard_amt(hazard_amt), .pending(pending), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: absolute ready cycles ----------------
  longint now_n = 0;
  longint ready [N];
  longint old_ready [N];
  bit [N-1:0] prev_mask;
  bit prev_valid;
  bit model_ok = 1'b0;

  function automatic int val(input int i);
    return (ready[i] > now_n) ? int'(ready[i] - now_n) : 0;
  endfunction

  task automatic model_step();
    bit [N-1:0] m;
    now_n++;
    if (rst) begin
      for (int i = 0; i < N; i++) ready[i] = now_n;
      prev_valid = 1'b0;
      prev_mask  = '0;
      model_ok   = 1'b1;
      return;
    end
    if (flush) begin
      if (prev_valid)
        for (int i = 0; i < N; i++) if (prev_mask[i]) ready[i] = old_ready[i];
      prev_valid = 1'b0;
      prev_mask  = '0;
    end else if (issue_valid) begin
      m = '0;
      if (issue_lat != 0) begin
        if (issue_we && issue_dst != 0) m[issue_dst] = 1'b1;
        if (issue_hi) m[32] = 1'b1;
        if (issue_lo) m[33] = 1'b1;
      end
      for (int i = 0; i < N; i++) old_ready[i] = ready[i];
      for (int i = 0; i < N; i++) if (m[i]) ready[i] = now_n + longint'(issue_lat);
      prev_valid = 1'b1;
      prev_mask  = m;
    end else begin
      prev_valid = 1'b0;
      prev_mask  = '0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    bit [N-1:0] exp_pend;
    int exp_amt;
    exp_amt = 0;
    for (int i = 0; i < N; i++) exp_pend[i] = (val(i) != 0);
    if (src1_used && src1 != 0 && val(int'(src1)) > exp_amt) exp_amt = val(int'(src1));
    if (src2_used && src2 != 0 && val(int'(src2)) > exp_amt) exp_amt = val(int'(src2));
    if (src_hi && val(32) > exp_amt) exp_amt = val(32);
    if (src_lo && val(33) > exp_amt) exp_amt = val(33);
    check("model.hazard",     64'(hazard),     64'(exp_amt != 0));
    check("model.hazard_amt", 64'(hazard_amt), 64'(exp_amt));
    check("model.pending",    64'(pending),    64'(exp_pend));
    check("model.idle",       64'(idle),       64'(exp_pend == '0));
  endtask

  task automatic idle_inputs();
    rst = 1'b0; issue_valid = 1'b0; issue_we = 1'b0; issue_dst = '0;
    issue_hi = 1'b0; issue_lo = 1'b0; issue_lat = '0;
    src1 = '0; src1_used = 1'b0; src2 = '0; src2_used = 1'b0;
    src_hi = 1'b0; src_lo = 1'b0; flush = 1'b0;
  endtask

  // Compare the current cycle, apply the driven inputs at the next edge, return mid-low-phase.
  task automatic step();
    #1;
    if (model_ok) compare_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic expect_q(input string name, input bit exp_h, input int exp_a);
    #1;
    check({name, ".hazard"}, 64'(hazard), 64'(exp_h));
    check({name, ".amt"},    64'(hazard_amt), 64'(exp_a));
  endtask

  task automatic issue_gpr(input int dst, input int lat);
    issue_valid = 1'b1; issue_we = 1'b1;
    issue_dst = 5'(dst); issue_lat = LAT_W'(lat);
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < N; i++) begin ready[i] = 0; old_ready[i] = 0; end
    prev_mask = '0; prev_valid = 1'b0;
    @(negedge clk);

    // Reset, then no activity.
    rst = 1'b1; step();
    rst = 1'b1; step();
    step();
    src1 = 5'd3; src1_used = 1'b1;
    expect_q("reset", 1'b0, 0);
    check("reset.pending", 64'(pending), 64'h0);
    check("reset.idle",    64'(idle),    64'h1);
    step();

    // dst 5 latency 3: stall counts 3,2,1 then clear.
    issue_gpr(5, 3); step();
    src1 = 5'd5; src1_used = 1'b1; expect_q("lat3.c1", 1'b1, 3); step();
    src1 = 5'd5; src1_used = 1'b1; expect_q("lat3.c2", 1'b1, 2); step();
    src1 = 5'd5; src1_used = 1'b1; expect_q("lat3.c3", 1'b1, 1); step();
    src1 = 5'd5; src1_used = 1'b1; expect_q("lat3.c4", 1'b0, 0);
    check("lat3.idle", 64'(idle), 64'h1);
    step();

    // GPR 0 and zero latency are never tracked.
    issue_gpr(0, 3); step();
    issue_gpr(7, 0); step();
    src1 = 5'd0; src1_used = 1'b1; src2 = 5'd7; src2_used = 1'b1;
    expect_q("zero", 1'b0, 0);
    check("zero.pending", 64'(pending), 64'h0);
    step();

    // WAW: second load wins over the decrement.
    issue_gpr(4, 2); step();
    issue_gpr(4, 3); step();
    src2 = 5'd4; src2_used = 1'b1; src1 = 5'd9; src1_used = 1'b0;
    expect_q("waw", 1'b1, 3);
    check("waw.pending", 64'(pending), 64'h10);
    step();
    src1 = 5'd4; src1_used = 1'b0;
    expect_q("unused", 1'b0, 0);
    step(); step(); step();

    // Squash: entry 6 restored to (1 - 2) saturated, squashed issue to 8 dropped.
    issue_gpr(6, 1); step();
    issue_gpr(6, 3); step();
    flush = 1'b1; issue_gpr(8, 5);
    src1 = 5'd6; src1_used = 1'b1;
    expect_q("flush.before", 1'b1, 3);
    step();
    src1 = 5'd6; src1_used = 1'b1; src2 = 5'd8; src2_used = 1'b1;
    expect_q("flush.after", 1'b0, 0);
    check("flush.pending", 64'(pending), 64'h0);
    step();

    // HI tracking, then reset mid-count.
    issue_valid = 1'b1; issue_hi = 1'b1; issue_lat = 3'd4; step();
    src_hi = 1'b1; expect_q("hi", 1'b1, 4);
    check("hi.pending", 64'(pending), 64'h1_0000_0000);
    step();
    rst = 1'b1; src_hi = 1'b1; expect_q("hi.prerst", 1'b1, 3); step();
    src_hi = 1'b1; expect_q("hi.rst", 1'b0, 0);
    check("hi.rst.pending", 64'(pending), 64'h0);
    check("hi.rst.idle",    64'(idle),    64'h1);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 249) == 0);
      issue_valid = 1'($urandom_range(0, 1));
      issue_we    = ($urandom_range(0, 3) != 0);
      issue_dst   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      issue_hi    = ($urandom_range(0, 5) == 0);
      issue_lo    = ($urandom_range(0, 5) == 0);
      issue_lat   = LAT_W'($urandom_range(0, 7));
      src1        = 5'($urandom_range(0, 7));
      src1_used   = ($urandom_range(0, 3) != 0);
      src2        = 5'($urandom_range(0, 7));
      src2_used   = ($urandom_range(0, 3) != 0);
      src_hi      = ($urandom_range(0, 3) == 0);
      src_lo      = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
